// File: rtl/tx_irq_coalesce_gen_if.sv
// Bundles the Tx-side requests, host pointer updates and the MSI handshake of
// tx_irq_coalesce_gen. The slave modport is the generator; master is its environment.
interface tx_irq_coalesce_gen_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned PTR_W  = 64,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned TMR_W  = 16
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]       data_rdy;
   logic [NUM_CH-1:0]       data_rdy_ack;
   logic [NUM_CH*PTR_W-1:0] hw_ptr;
   logic [NUM_CH-1:0]       sw_ptr_update;
   logic [NUM_CH*PTR_W-1:0] sw_ptr;
   logic [NUM_CH-1:0]       irq_en;
   logic [CNT_W-1:0]        coal_cnt;
   logic [TMR_W-1:0]        coal_tmr;
   logic                    send_irq;
   logic [CH_W-1:0]         irq_ch;
   logic                    irq_ack;

   modport master (
      output data_rdy,
      output hw_ptr,
      output sw_ptr_update,
      output sw_ptr,
      output irq_en,
      output coal_cnt,
      output coal_tmr,
      output irq_ack,
      input  data_rdy_ack,
      input  send_irq,
      input  irq_ch
   );

   modport slave (
      input  data_rdy,
      input  hw_ptr,
      input  sw_ptr_update,
      input  sw_ptr,
      input  irq_en,
      input  coal_cnt,
      input  coal_tmr,
      input  irq_ack,
      output data_rdy_ack,
      output send_irq,
      output irq_ch
   );
endinterface

// File: rtl/tx_irq_coalesce_gen.sv
// Multi-channel Tx interrupt generator: per-channel request FSMs feeding one round-robin
// MSI request. Define IRQ_COALESCE_EN to hold requests in PEND until count/timeout coalescing.
module tx_irq_coalesce_gen #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned PTR_W  = 64,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned TMR_W  = 16
) (
   input logic                  clk,
   input logic                  rst,
   tx_irq_coalesce_gen_if.slave bus
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [2:0] {StIdle, StPend, StReq, StWaitSw, StChk} ch_state_e;

   ch_state_e             state_q [NUM_CH];
   ch_state_e             state_d [NUM_CH];
   logic [NUM_CH-1:0]     ack_q;
   logic [NUM_CH-1:0]     accept;
   logic [NUM_CH-1:0]     eligible;
   logic [NUM_CH-1:0]     ptr_match;
   logic [NUM_CH-1:0]     pend_done;

   logic                  send_q, send_d;
   logic [CH_W-1:0]       ch_q, ch_d;
   logic [CH_W-1:0]       rr_q, rr_d;
   logic                  grant_vld;
   logic [CH_W-1:0]       grant_idx;
   logic [2*NUM_CH-1:0]   elig_rot;
   logic [CH_W:0]         cand;
   logic                  ack_take;

   assign ack_take = send_q & bus.irq_ack;

   // Per-channel state register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) state_q[i] <= StIdle;
         ack_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
         ack_q <= accept;
      end
   end

   // Per-channel next state
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            StIdle:   if (accept[i]) state_d[i] = StPend;
            StPend:   if (pend_done[i]) state_d[i] = StReq;
            StReq:    if (ack_take && (ch_q == CH_W'(i))) state_d[i] = StWaitSw;
            StWaitSw: if (bus.sw_ptr_update[i]) state_d[i] = StChk;
            StChk:    if (ptr_match[i]) state_d[i] = StIdle;
            default:  state_d[i] = StIdle;
         endcase
      end
   end

   // Per-channel decoded outputs and module outputs
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         // The ack pulse blocks re-acceptance of a level request in the following cycle.
         accept[i]    = bus.data_rdy[i] & ~ack_q[i] &
                        ((state_q[i] == StIdle) | (state_q[i] == StPend));
         eligible[i]  = (state_q[i] == StReq) & bus.irq_en[i];
         ptr_match[i] = (bus.hw_ptr[i*PTR_W +: PTR_W] == bus.sw_ptr[i*PTR_W +: PTR_W]);
      end
      bus.data_rdy_ack = ack_q;
      bus.send_irq     = send_q;
      bus.irq_ch       = ch_q;
   end

`ifdef IRQ_COALESCE_EN
   logic [CNT_W-1:0] cnt_q [NUM_CH];
   logic [CNT_W-1:0] cnt_d [NUM_CH];
   logic [TMR_W-1:0] tmr_q [NUM_CH];
   logic [TMR_W-1:0] tmr_d [NUM_CH];

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         tmr_d[i] = tmr_q[i];
         if ((state_q[i] == StIdle) && accept[i]) begin
            cnt_d[i] = CNT_W'(1);
            tmr_d[i] = '0;
         end else begin
            if (accept[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + 1'b1;
            if ((state_q[i] == StPend) && (tmr_q[i] != '1)) tmr_d[i] = tmr_q[i] + 1'b1;
            if ((state_q[i] == StChk) && ptr_match[i]) cnt_d[i] = '0;
         end
         pend_done[i] = (cnt_q[i] >= bus.coal_cnt) || (tmr_q[i] >= bus.coal_tmr) ||
                        (bus.coal_cnt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
            tmr_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
            tmr_q[i] <= tmr_d[i];
         end
      end
   end
`else
   logic unused_coal;
   assign unused_coal = ^{bus.coal_cnt, bus.coal_tmr};
   assign pend_done   = '1;
`endif

   // Round-robin pick: rotate eligibility so bit 0 is rr_q, take the lowest set bit.
   always_comb begin
      elig_rot  = {eligible, eligible} >> rr_q;
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!grant_vld && elig_rot[k]) begin
            grant_vld = 1'b1;
            cand      = {1'b0, rr_q} + (CH_W+1)'(k);
            if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
            grant_idx = cand[CH_W-1:0];
         end
      end
   end

   // A new grant is only taken while send_q is low, which forces an idle cycle after each ack.
   always_comb begin
      send_d = send_q;
      ch_d   = ch_q;
      rr_d   = rr_q;
      if (send_q) begin
         if (bus.irq_ack) begin
            send_d = 1'b0;
            rr_d   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
         end
      end else if (grant_vld) begin
         send_d = 1'b1;
         ch_d   = grant_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         send_q <= 1'b0;
         ch_q   <= '0;
         rr_q   <= '0;
      end else begin
         send_q <= send_d;
         ch_q   <= ch_d;
         rr_q   <= rr_d;
      end
   end

   a_req_held: assert property (@(posedge clk) disable iff (rst)
      (send_q && !bus.irq_ack) |=> (send_q && $stable(ch_q)));
   a_idle_gap: assert property (@(posedge clk) disable iff (rst)
      (send_q && bus.irq_ack) |=> !send_q);
endmodule
